// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order imem requests and buffers returned words for decode.
// Optional `FETCH_PERF_CNT_EN adds perf_fetched / perf_stalled counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalled
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fifo_entry_t;

    fifo_entry_t   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count, outstanding, drop_cnt;
    logic [31:0]   fetch_pc, rsp_pc;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_drop, push, pop;

    // Credit uses registered occupancy only, so stall never reaches the request path;
    // a pop therefore frees credit for the following cycle.
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    assign push           = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign if_valid       = (fifo_count != '0);
    assign pop            = if_valid && !stall && !redirect_valid;
    assign if_instruction = fifo_mem[rd_ptr].instr;
    assign if_pc          = fifo_mem[rd_ptr].pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Every request still in flight is stale; one returning now is dropped here.
                fetch_pc   <= redirect_pc;
                rsp_pc     <= redirect_pc;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                drop_cnt   <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    fifo_mem[wr_ptr] <= '{instr: imem_rsp_data, pc: rsp_pc};
                    wr_ptr           <= wr_ptr + AW'(1);
                    rsp_pc           <= rsp_pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
        end else begin
            if (pop)              perf_fetched <= perf_fetched + 32'd1;
            if (if_valid && stall) perf_stalled <= perf_stalled + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reset-release vector table, directed redirect/stall cases,
// and a randomized run against a queue-based memory and instruction-stream reference.
module tb_fetch_stage;
    localparam int          D = 2;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction, if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalled;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_stalled(perf_stalled),
`endif
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
    );

    // Reference: memory holds accepted requests; buffered counts good words not yet consumed.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;
    mreq_t       mq[$];
    int          cyc, last_due, lat_min, lat_max, buffered, n_pop, n_stv;
    logic [31:0] exp_pc, exp_fetch;

    logic        s_if_valid, s_req_valid, s_popped;
    logic [31:0] s_if_pc, s_req_addr, s_pop_pc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 0; redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instruction, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_req_valid", imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_stalled", perf_stalled, 0);
`endif
        mq.delete();
        cyc = 1; last_due = 0; buffered = 0; n_pop = 0; n_stv = 0;
        exp_pc = 32'h0; exp_fetch = 32'h0;
    endtask

    // One cycle: drive inputs at negedge, sample/check at +1, advance the reference.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit rsp, stale, popped;
        int l, due;
        @(negedge clk);
        rst = 1'b0; stall = st; redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rdy;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? (mq[0].addr ^ K) : $urandom;
        #1;
        s_if_valid = if_valid; s_if_pc = if_pc;
        s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
        chk("if_valid", if_valid, 32'(buffered > 0));
        if (if_valid) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instruction, exp_pc ^ K);
        end
        chk("req_valid", imem_req_valid, 32'(!rd && (mq.size() + buffered < D)));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);

        stale  = rsp ? mq[0].stale : 1'b0;
        if (rsp) void'(mq.pop_front());
        popped = if_valid && !st && !rd;
        s_popped = popped; s_pop_pc = if_pc;
        if (popped) begin n_pop++; exp_pc += 32'd4; end
        if (if_valid && st) n_stv++;
        if (rd) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            buffered = 0; exp_pc = rpc; exp_fetch = rpc;
        end else begin
            if (rsp && !stale) buffered++;
            if (popped) buffered--;
        end
        if (imem_req_valid && rdy) begin
            l   = int'($urandom_range(lat_max, lat_min));
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{addr: exp_fetch, due: due, stale: 1'b0});
            last_due = due;
            exp_fetch += 32'd4;
        end
        cyc++;
    endtask

    typedef struct {
        bit          st;
        bit          ev;
        logic [31:0] epc;
        bit          erv;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vt[12];

    initial begin
        bit          found;
        int          npops;
        logic [31:0] pcs[2];

        // Reset release, ready=1, L=1: credit limits issue, stall freezes the head.
        vt[0]  = '{0, 0, 32'h00, 1, 32'h00};
        vt[1]  = '{0, 0, 32'h00, 1, 32'h04};
        vt[2]  = '{0, 1, 32'h00, 0, 32'h00};
        vt[3]  = '{0, 1, 32'h04, 1, 32'h08};
        vt[4]  = '{0, 0, 32'h00, 1, 32'h0C};
        vt[5]  = '{0, 1, 32'h08, 0, 32'h00};
        vt[6]  = '{0, 1, 32'h0C, 1, 32'h10};
        vt[7]  = '{1, 0, 32'h00, 1, 32'h14};
        vt[8]  = '{1, 1, 32'h10, 0, 32'h00};
        vt[9]  = '{1, 1, 32'h10, 0, 32'h00};
        vt[10] = '{0, 1, 32'h10, 0, 32'h00};
        vt[11] = '{0, 1, 32'h14, 1, 32'h18};

        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vt[i].st, 1'b0, 32'h0, 1'b1);
            chk($sformatf("vec%0d_if_valid", i), s_if_valid, 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d_if_pc", i), s_if_pc, vt[i].epc);
            chk($sformatf("vec%0d_req_valid", i), s_req_valid, 32'(vt[i].erv));
            if (vt[i].erv) chk($sformatf("vec%0d_req_addr", i), s_req_addr, vt[i].eaddr);
        end

        // Stall held 5 cycles, then release.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x100 with two requests in flight at L=3.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() == 2 && !mq[0].stale && !mq[1].stale) begin
                step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
                found = 1;
            end else step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("redir_found", found, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_if_valid_next", s_if_valid, 0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_if_valid) begin
                found = 1;
                chk("redir_first_pc", s_if_pc, 32'h0000_0100);
            end
        end
        chk("redir_first_seen", found, 1);

        // Redirect coinciding with a response and a held head under stall.
        lat_min = 1; lat_max = 2;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && if_valid) begin
                step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
                found = 1;
            end else step(i % 3 == 0, 1'b0, 32'h0, 1'b1);
        end
        chk("rsp_redir_found", found, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rsp_redir_flush", s_if_valid, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap at 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        npops = 0;
        for (int i = 0; i < 40 && npops < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_popped) begin pcs[npops] = s_pop_pc; npops++; end
        end
        chk("wrap_pops", npops, 2);
        chk("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", pcs[1], 32'h0000_0000);

        // Mid-operation reset, then 10 pops with 3 stalled-valid cycles.
        do_reset();
        for (int i = 0; i < 200 && n_pop < 10; i++)
            step(if_valid && n_stv < 3 && n_pop >= 2, 1'b0, 32'h0, 1'b1);
        chk("perf_phase_pops", n_pop, 10);
        chk("perf_phase_stalls", n_stv, 3);
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        chk("perf_fetched_10", perf_fetched, 32'd10);
        chk("perf_stalled_3", perf_stalled, 32'd3);
`endif

        // Randomized: ready toggling, stalls, occasional redirects, latency 1..3.
        lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            bit rd;
            rd = ($urandom_range(39, 0) == 0);
            step($urandom_range(3, 0) == 0, rd, $urandom, $urandom_range(1, 0) == 1);
        end
        chk("rand_progress", 32'(n_pop > 100), 1);
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        chk("rand_perf_fetched", perf_fetched, n_pop);
        chk("rand_perf_stalled", perf_stalled, n_stv);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
